muldiv_unit: RTL

- Iterative HI/LO multiply/divide unit. It sits beside the EX stage of the datapath.
- It is started by the MULT/MULTU/DIV/DIVU decode from the controller and written directly by MTHI/MTLO.
- The datapath reads hi/lo as the HIGH_OUT/LOW_OUT write-back sources.
- busy stalls the pipeline while an operation is in flight.

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit beside the EX stage.
// Ports: clock, reset (async, active-high); start/op/src_a/src_b launch
// MULT/MULTU/DIV/DIVU; mthi/mtlo write src_a into hi/lo; flush aborts;
// busy stalls HI/LO consumers; done pulses when hi/lo take a result.
module muldiv_unit #(
    parameter int         WIDTH    = 32,
    parameter logic [1:0] OP_MULT  = 2'b00,
    parameter logic [1:0] OP_MULTU = 2'b01,
    parameter logic [1:0] OP_DIV   = 2'b10,
    parameter logic [1:0] OP_DIVU  = 2'b11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand conditioning at start
    logic             is_signed;
    logic             is_div_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg     = is_signed & src_a[WIDTH-1];
    assign b_neg     = is_signed & src_b[WIDTH-1];
    assign a_mag     = a_neg ? ({WIDTH{1'b0}} - src_a) : src_a;
    assign b_mag     = b_neg ? ({WIDTH{1'b0}} - src_b) : src_b;

    // Multiply step: acc holds {partial product, remaining multiplier bits};
    // add the multiplicand on the upper half when the next bit is 1, then
    // shift right, letting the carry land in the top bit.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mult_next;

    assign msum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mult_next = {msum, acc_q[WIDTH-1:1]};

    // Divide step: acc holds {remainder, dividend bits / quotient bits}.
    // The remainder stays below the divisor, so it fits WIDTH bits; only
    // the shifted trial value needs the extra bit.
    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] div_next;

    assign shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign fits     = shifted >= {1'b0, opnd_q};
    assign diff     = shifted[WIDTH-1:0] - opnd_q;
    assign div_next = {(fits ? diff : shifted[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], fits};

    // Sign correction
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
    // Divide by zero yields an all-ones quotient regardless of sign
    assign quo_fix  = dz_q  ? {WIDTH{1'b1}}
                    : neg_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0])
                    : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH])
                    : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = CW'(1);
                    is_div_d = is_div_op;
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = is_div_op & a_neg;
                    dz_d     = is_div_op & (src_b == {WIDTH{1'b0}});
                    if (is_div_op) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end else begin
                    if (mthi) hi_d = src_a;
                    if (mtlo) lo_d = src_a;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mult_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
